// File: rtl/ltl_cluster_pkg.sv
// Shared types, default parameter values and slice helper for the LTL cluster monitor.
package ltl_cluster_pkg;

  localparam int DEF_NUM_PROPS        = 3;
  localparam int DEF_REPORTS_PER_PROP = 4;
  localparam int DEF_SYM_W            = 8;
  localparam int DEF_CNT_W            = 16;
  localparam int DEF_TS_W             = 32;

  // Clear handshake: one ACK cycle, then wait for the request to drop.
  typedef enum logic [1:0] {
    CLR_IDLE     = 2'd0,
    CLR_ACK      = 2'd1,
    CLR_WAIT_LOW = 2'd2
  } clr_state_t;

  // Low bit index of property p's slice in a flat per-property bus.
  function automatic int slice_lo(input int p, input int w);
    return p * w;
  endfunction

endpackage

// File: rtl/ltl_prop_tracker.sv
// Per-property sticky flag, saturating hit counter and optional first-hit timestamp.
// Optional feature: LTL_FIRST_HIT_TS_EN adds the ts input and first_ts output.
module ltl_prop_tracker
  import ltl_cluster_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TS_W  = DEF_TS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hit,
  input  logic             clr,
`ifdef LTL_FIRST_HIT_TS_EN
  input  logic [TS_W-1:0]  ts,
  output logic [TS_W-1:0]  first_ts,
`endif
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Clear wins first, then a coincident hit is applied on top of the cleared state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (clr) begin
      sticky <= hit;
      cnt    <= hit ? CNT_ONE : '0;
    end else if (hit) begin
      sticky <= 1'b1;
      cnt    <= (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    end
  end

`ifdef LTL_FIRST_HIT_TS_EN
  // Capture the cycle count on the first hit since the last clear (sticky still low).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      first_ts <= '0;
    end else if (clr) begin
      first_ts <= hit ? ts : '0;
    end else if (hit && !sticky) begin
      first_ts <= ts;
    end
  end
`endif

endmodule

// File: rtl/ltl_cluster_monitor.sv
// LTL cluster monitor: per-property hit detection, sticky/counter tracking, clear handshake.
// Optional feature: LTL_FIRST_HIT_TS_EN adds a free-running cycle counter and first_ts port.
module ltl_cluster_monitor
  import ltl_cluster_pkg::*;
#(
  parameter int NUM_PROPS        = DEF_NUM_PROPS,
  parameter int REPORTS_PER_PROP = DEF_REPORTS_PER_PROP,
  parameter int SYM_W            = DEF_SYM_W,
  parameter int CNT_W            = DEF_CNT_W,
  parameter int TS_W             = DEF_TS_W
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                run,
  input  logic [SYM_W-1:0]                    symbols,
  input  logic [NUM_PROPS*REPORTS_PER_PROP-1:0] report_in,
  input  logic [NUM_PROPS-1:0]                prop_mask,
  input  logic                                clr_req,
  output logic [NUM_PROPS-1:0]                ltl_out,
  output logic [NUM_PROPS-1:0]                ltl_sticky,
  output logic                                any_hit,
  output logic [NUM_PROPS*CNT_W-1:0]          hit_cnt,
  output logic                                clr_ack,
`ifdef LTL_FIRST_HIT_TS_EN
  output logic [NUM_PROPS*TS_W-1:0]           first_ts,
`endif
  output logic [SYM_W-1:0]                    out_symbols
);

  logic [NUM_PROPS-1:0] hit;
  clr_state_t           state, state_nxt;
  logic                 clr_pulse;

  // Per-property hit: report slice OR-reduced, gated by run and mask.
  for (genvar p = 0; p < NUM_PROPS; p++) begin : g_hit
    assign hit[p] = run & prop_mask[p] &
                    (|report_in[slice_lo(p, REPORTS_PER_PROP) +: REPORTS_PER_PROP]);
  end

  // Hit and symbol pipeline registers; hit already carries run so ltl_out drops after run=0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ltl_out     <= '0;
      out_symbols <= '0;
    end else begin
      ltl_out     <= hit;
      out_symbols <= symbols;
    end
  end

  // Clear FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLR_IDLE;
    else       state <= state_nxt;
  end

  // Clear FSM next-state; a request held high is ignored until it returns low.
  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR_IDLE:     if (clr_req)  state_nxt = CLR_ACK;
      CLR_ACK:                    state_nxt = CLR_WAIT_LOW;
      CLR_WAIT_LOW: if (!clr_req) state_nxt = CLR_IDLE;
      default:                    state_nxt = CLR_IDLE;
    endcase
  end

  assign clr_pulse = (state == CLR_IDLE) && clr_req;
  assign clr_ack   = (state == CLR_ACK);
  assign any_hit   = |ltl_sticky;

`ifdef LTL_FIRST_HIT_TS_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running cycle counter; only reset clears it, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + TS_W'(1);
  end
`endif

  for (genvar p = 0; p < NUM_PROPS; p++) begin : g_trk
    ltl_prop_tracker #(
      .CNT_W (CNT_W),
      .TS_W  (TS_W)
    ) u_trk (
      .clk      (clk),
      .reset    (reset),
      .hit      (hit[p]),
      .clr      (clr_pulse),
`ifdef LTL_FIRST_HIT_TS_EN
      .ts       (ts_cnt),
      .first_ts (first_ts[p*TS_W +: TS_W]),
`endif
      .sticky   (ltl_sticky[p]),
      .cnt      (hit_cnt[p*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_ltl_cluster_monitor.sv
// Directed table-driven bench for ltl_cluster_monitor (3 props, 4 reports each, 4-bit counters).
module tb_ltl_cluster_monitor;

  localparam int NP = 3;
  localparam int RP = 4;
  localparam int SW = 8;
  localparam int CW = 4;
  localparam int TW = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               run;
  logic [SW-1:0]      symbols;
  logic [NP*RP-1:0]   report_in;
  logic [NP-1:0]      prop_mask;
  logic               clr_req;
  logic [NP-1:0]      ltl_out;
  logic [NP-1:0]      ltl_sticky;
  logic               any_hit;
  logic [NP*CW-1:0]   hit_cnt;
  logic               clr_ack;
  logic [SW-1:0]      out_symbols;
`ifdef LTL_FIRST_HIT_TS_EN
  logic [NP*TW-1:0]   first_ts;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ltl_cluster_monitor #(
    .NUM_PROPS(NP), .REPORTS_PER_PROP(RP), .SYM_W(SW), .CNT_W(CW), .TS_W(TW)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .symbols(symbols), .report_in(report_in),
    .prop_mask(prop_mask), .clr_req(clr_req), .ltl_out(ltl_out), .ltl_sticky(ltl_sticky),
    .any_hit(any_hit), .hit_cnt(hit_cnt), .clr_ack(clr_ack),
`ifdef LTL_FIRST_HIT_TS_EN
    .first_ts(first_ts),
`endif
    .out_symbols(out_symbols)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          run;
    logic [SW-1:0] sym;
    logic [11:0]   rep;
    logic [2:0]    mask;
    logic          clr;
    logic [2:0]    e_out;
    logic [2:0]    e_sticky;
    logic [11:0]   e_cnt;
    logic          e_ack;
    logic [SW-1:0] e_sym;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic [SW-1:0] s, input logic [11:0] rep,
                       input logic [2:0] m, input logic c);
    run = r; symbols = s; report_in = rep; prop_mask = m; clr_req = c;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ltl_out"},     32'(ltl_out), 0);
    chk({tag, " sticky"},      32'(ltl_sticky), 0);
    chk({tag, " any_hit"},     32'(any_hit), 0);
    chk({tag, " hit_cnt"},     32'(hit_cnt), 0);
    chk({tag, " clr_ack"},     32'(clr_ack), 0);
    chk({tag, " out_symbols"}, 32'(out_symbols), 0);
  endtask

  initial begin
    int acks;
    //         run sym    rep     mask  clr  out   sticky cnt     ack sym
    vecs[0]  = '{1, 8'hA1, 12'h040, 3'b111, 0, 3'b010, 3'b010, 12'h010, 0, 8'hA1};
    vecs[1]  = '{1, 8'hB2, 12'h000, 3'b111, 0, 3'b000, 3'b010, 12'h010, 0, 8'hB2};
    vecs[2]  = '{1, 8'hC3, 12'hFFF, 3'b101, 0, 3'b101, 3'b111, 12'h111, 0, 8'hC3};
    vecs[3]  = '{0, 8'hD4, 12'hFFF, 3'b111, 0, 3'b000, 3'b111, 12'h111, 0, 8'hD4};
    vecs[4]  = '{0, 8'hE5, 12'h000, 3'b111, 1, 3'b000, 3'b000, 12'h000, 1, 8'hE5};
    vecs[5]  = '{1, 8'h16, 12'h00F, 3'b111, 1, 3'b001, 3'b001, 12'h001, 0, 8'h16};
    vecs[6]  = '{0, 8'h27, 12'h000, 3'b111, 1, 3'b000, 3'b001, 12'h001, 0, 8'h27};
    vecs[7]  = '{0, 8'h38, 12'h000, 3'b111, 0, 3'b000, 3'b001, 12'h001, 0, 8'h38};
    vecs[8]  = '{1, 8'h49, 12'hF00, 3'b111, 1, 3'b100, 3'b100, 12'h100, 1, 8'h49};
    vecs[9]  = '{0, 8'h5A, 12'h000, 3'b111, 0, 3'b000, 3'b100, 12'h100, 0, 8'h5A};
    vecs[10] = '{0, 8'h6B, 12'h000, 3'b111, 0, 3'b000, 3'b100, 12'h100, 0, 8'h6B};

    // Reset state, checked without waiting for an edge.
    reset = 1'b1;
    drive(0, 8'hFF, 12'hFFF, 3'b111, 0);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Table: inputs applied before an edge, outputs checked just after it.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].run, vecs[i].sym, vecs[i].rep, vecs[i].mask, vecs[i].clr);
      step();
      chk($sformatf("v%0d ltl_out", i), 32'(ltl_out), 32'(vecs[i].e_out));
      chk($sformatf("v%0d sticky", i),  32'(ltl_sticky), 32'(vecs[i].e_sticky));
      chk($sformatf("v%0d any_hit", i), 32'(any_hit), 32'(|vecs[i].e_sticky));
      chk($sformatf("v%0d hit_cnt", i), 32'(hit_cnt), 32'(vecs[i].e_cnt));
      chk($sformatf("v%0d clr_ack", i), 32'(clr_ack), 32'(vecs[i].e_ack));
      chk($sformatf("v%0d out_sym", i), 32'(out_symbols), 32'(vecs[i].e_sym));
    end

    // Saturation: property 0 hit 20 cycles (count was 0) -> 15, then held.
    drive(1, 8'h00, 12'h00F, 3'b111, 0);
    repeat (20) step();
    chk("sat cnt0", 32'(hit_cnt[3:0]), 15);
    step();
    chk("sat held", 32'(hit_cnt[3:0]), 15);
    chk("sat cnt2 untouched", 32'(hit_cnt[11:8]), 1);

    // clr_req held 5 cycles: one ack, one zeroing; a hit in WAIT_LOW survives.
    acks = 0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) drive(1, 8'h00, 12'h00F, 3'b111, 1);
      else        drive(0, 8'h00, 12'h000, 3'b111, 1);
      step();
      if (clr_ack) acks++;
      if (c == 0) chk("hold first clear cnt", 32'(hit_cnt), 0);
    end
    n_tests++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL hold ack count: got %0d expected 1", acks);
    end
    chk("hold no second zero", 32'(hit_cnt), 12'h001);
    drive(0, 8'h00, 12'h000, 3'b111, 0);
    step();
    drive(0, 8'h00, 12'h000, 3'b111, 1);
    step();
    chk("second ack", 32'(clr_ack), 1);
    chk("second clear cnt", 32'(hit_cnt), 0);
    drive(0, 8'h00, 12'h000, 3'b111, 0);
    step();
    step();

    // Reset mid-ACK: everything zero at once, then a held clr_req starts a new clear.
    drive(1, 8'h00, 12'hFFF, 3'b111, 0);
    step();
    chk("pre-ack sticky", 32'(ltl_sticky), 3'b111);
    drive(1, 8'h55, 12'hFFF, 3'b111, 1);
    step();
    chk("in ACK", 32'(clr_ack), 1);
    chk("in ACK out_sym", 32'(out_symbols), 8'h55);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("midack");
    drive(0, 8'h00, 12'h000, 3'b111, 1);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("post-reset ack", 32'(clr_ack), 1);

`ifdef LTL_FIRST_HIT_TS_EN
    // First hit presented at the 8th edge after reset release (counter = 7).
    drive(0, 8'h00, 12'h000, 3'b111, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    drive(1, 8'h00, 12'h00F, 3'b001, 0);
    step();
    chk("first_ts p0", first_ts[31:0], 7);
    chk("first_ts p1", first_ts[63:32], 0);
    step();
    chk("first_ts p0 held", first_ts[31:0], 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, limit 200000 expected earlier");
    $fatal(1);
  end

endmodule
